pulse_gen_multi: RTL



---
 rtl/pulse_gen_pkg.sv | 28 ++
 rtl/pulse_gen_channel.sv | 152 +++++++++++++++
 rtl/pulse_gen_multi.sv | 61 ++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared types and defaults for the multi-channel pulse generator.
//   pg_state_e   : per-channel FSM state (2-bit encoding)
//   PG_CNT_W     : default width of the delay/width counters
//   PG_CHANNELS  : default channel count
//   pg_is_busy() : states during which a channel reports busy
// Optional build macro used by the channel: PULSE_GEN_NEGEDGE_OUT_EN.
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,  // waiting for the trigger level to be high
    ARMED     = 2'd1,  // high seen, next low sample fires the channel
    DELAY     = 2'd2,  // counting down the captured delay
    PULSE     = 2'd3   // output active, counting down the captured width
  } pg_state_e;

  localparam int PG_CNT_W    = 8;
  localparam int PG_CHANNELS = 4;

  // busy is a pure function of the state being entered, so it can be
  // registered alongside the state without a separate decode later.
  function automatic logic pg_is_busy(input pg_state_e s);
    return (s == DELAY) || (s == PULSE);
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// -----------------------------------------------------------------------------
// pulse_gen_channel
// One pulse-generator channel: detects a low-going trigger (after the level has
// been seen high), waits 'delay' cycles, then drives an output pulse that is
// exactly 'width' cycles long. delay/width are captured at the trigger edge.
//
// Ports
//   clk     in   system clock (all state on rising edge)
//   reset   in   synchronous active-high; channel -> WAIT_HIGH, out inactive
//   enable  in   low aborts the channel at that edge (same effect as reset)
//   in      in   trigger level
//   delay   in   CNT_W  delay in cycles between trigger and pulse start
//   width   in   CNT_W  pulse width in cycles (0 = trigger consumed, no pulse)
//   out     out  pulse output, idle level set by OUT_ACTIVE_LOW
//   busy    out  high while in DELAY or PULSE (registered)
//
// Build option
//   PULSE_GEN_NEGEDGE_OUT_EN : out is retimed through a falling-edge flop so
//   every out transition lands half a cycle after the rising edge that caused
//   it. busy is not retimed.
// -----------------------------------------------------------------------------
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W          = PG_CNT_W,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  // Output level when the pulse is not active; out = act ^ IDLE_LVL.
  localparam logic             IDLE_LVL = (OUT_ACTIVE_LOW != 0);

  pg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] wid_q,   wid_d;   // width captured at the trigger edge
  logic             act_q,   act_d;   // pulse active, polarity-neutral
  logic             busy_q,  busy_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      wid_q   <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    act_d   = act_q;

    if (!enable) begin
      // Abort takes effect at this very edge, truncating any pulse.
      state_d = WAIT_HIGH;
      cnt_d   = '0;
      act_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_HIGH: begin
          // Re-arm only once the level is back high, so a level held low
          // (after reset or after a pulse) never fires again.
          if (in) state_d = ARMED;
        end

        ARMED: begin
          if (!in) begin
            if (width == '0) begin
              // Zero width consumes the trigger without a pulse.
              state_d = WAIT_HIGH;
            end else begin
              state_d = DELAY;
              cnt_d   = delay;
              wid_d   = width;
            end
          end
        end

        DELAY: begin
          if (cnt_q == '0) begin
            state_d = PULSE;
            // wid_q is nonzero here: zero width never leaves ARMED for DELAY.
            cnt_d   = wid_q - ONE;
            act_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q - ONE;
          end
        end

        PULSE: begin
          if (cnt_q == '0) begin
            state_d = WAIT_HIGH;
            act_d   = 1'b0;
          end else begin
            cnt_d   = cnt_q - ONE;
          end
        end

        default: begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
          act_d   = 1'b0;
        end
      endcase
    end

    busy_d = pg_is_busy(state_d);
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef PULSE_GEN_NEGEDGE_OUT_EN
  // act_q is already cleared by a reset seen on the rising edge, so copying
  // it on the following falling edge gives the synchronous clear for free.
  logic out_n;

  always_ff @(negedge clk) begin
    out_n <= act_q ^ IDLE_LVL;
  end

  assign out = out_n;
`else
  assign out = act_q ^ IDLE_LVL;
`endif

endmodule

// File: rtl/pulse_gen_multi.sv
// -----------------------------------------------------------------------------
// pulse_gen_multi
// CHANNELS independent pulse-generator channels. Each channel fires on a
// high-to-low transition of its trigger, waits its delay, then emits a pulse of
// its width. Typical use: strobes derived from slow control levels (TCK/TRST
// gating, scan-path select strobes).
//
// Ports
//   clk     in   system clock
//   reset   in   synchronous active-high; every channel idles, outputs inactive
//   enable  in   [CHANNELS]        per-channel enable; low aborts the channel
//   in      in   [CHANNELS]        trigger levels, sampled on rising clk
//   delay   in   [CHANNELS*CNT_W]  channel i uses bits [i*CNT_W +: CNT_W]
//   width   in   [CHANNELS*CNT_W]  same packing as delay
//   out     out  [CHANNELS]        pulse outputs, polarity per OUT_ACTIVE_LOW
//   busy    out  [CHANNELS]        high while the channel is in DELAY or PULSE
//
// Build option (handled inside pulse_gen_channel)
//   PULSE_GEN_NEGEDGE_OUT_EN : out retimed to the falling clock edge.
// -----------------------------------------------------------------------------
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int CHANNELS       = PG_CHANNELS,
  parameter int CNT_W          = PG_CNT_W,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       in,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  input  logic [CHANNELS*CNT_W-1:0] width,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy
);

  // Packed 2-D views share the flat bus bit order: [i] == [i*CNT_W +: CNT_W].
  logic [CHANNELS-1:0][CNT_W-1:0] dly_a;
  logic [CHANNELS-1:0][CNT_W-1:0] wid_a;

  assign dly_a = delay;
  assign wid_a = width;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_gen_channel #(
      .CNT_W          (CNT_W),
      .OUT_ACTIVE_LOW (OUT_ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable[i]),
      .in     (in[i]),
      .delay  (dly_a[i]),
      .width  (wid_a[i]),
      .out    (out[i]),
      .busy   (busy[i])
    );
  end

endmodule
